// File: rtl/game_state_ctrl.sv
// Asteroid game sequencer: attract/play/dying/game-over phases, lives and strobes.
// Optional build macro GO_BLINK_EN makes the GAME OVER text blink.
module game_state_ctrl #(
    parameter int unsigned START_LIVES    = 3,
    parameter int unsigned LIFE_W         = 2,
    parameter int unsigned RESPAWN_FRAMES = 90,
    parameter int unsigned GO_HOLD_FRAMES = 180,
    parameter int unsigned BLINK_FRAMES   = 30
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iFrameTick,
    input  logic              iStart,
    input  logic              iShipHit,
    output logic [1:0]        oGameState,
    output logic [LIFE_W-1:0] oLives,
    output logic              oShowText,
    output logic              oFreeze,
    output logic              oRespawn,
    output logic              oResetScore
);

    localparam int unsigned MAXF = (RESPAWN_FRAMES > GO_HOLD_FRAMES) ? RESPAWN_FRAMES : GO_HOLD_FRAMES;
    localparam int unsigned CW   = $clog2(MAXF + 1);
    localparam logic [CW-1:0]     RESP_LAST = CW'(RESPAWN_FRAMES - 1);
    localparam logic [CW-1:0]     GO_HOLD   = CW'(GO_HOLD_FRAMES);
    localparam logic [LIFE_W-1:0] LIVES0    = LIFE_W'(START_LIVES);
    localparam logic [LIFE_W-1:0] ONE_LIFE  = LIFE_W'(1);

    typedef enum logic [1:0] {
        ST_ATTRACT   = 2'b00,
        ST_PLAY      = 2'b10,
        ST_DYING     = 2'b11,
        ST_GAME_OVER = 2'b01
    } state_t;

    state_t            r_state;
    logic [LIFE_W-1:0] r_lives;
    logic [CW-1:0]     r_cnt;
    logic              r_start_q;
    logic              r_show;
    logic              r_freeze;
    logic              r_respawn;
    logic              r_reset_score;
    logic              w_start_edge;

`ifdef GO_BLINK_EN
    localparam int unsigned BW = $clog2(BLINK_FRAMES + 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
    logic [BW-1:0] r_blink_cnt;
`endif

    assign w_start_edge = iStart & ~r_start_q;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state       <= ST_ATTRACT;
            r_lives       <= '0;
            r_cnt         <= '0;
            r_start_q     <= 1'b0;
            r_show        <= 1'b0;
            r_freeze      <= 1'b1;
            r_respawn     <= 1'b0;
            r_reset_score <= 1'b0;
`ifdef GO_BLINK_EN
            r_blink_cnt   <= '0;
`endif
        end else begin
            r_start_q     <= iStart;
            r_respawn     <= 1'b0;
            r_reset_score <= 1'b0;
            case (r_state)
                ST_ATTRACT: begin
                    r_freeze <= 1'b1;
                    r_show   <= 1'b0;
                    if (w_start_edge) begin
                        r_state       <= ST_PLAY;
                        r_lives       <= LIVES0;
                        r_cnt         <= '0;
                        r_freeze      <= 1'b0;
                        r_respawn     <= 1'b1;
                        r_reset_score <= 1'b1;
                    end
                end
                ST_PLAY: begin
                    r_freeze <= 1'b0;
                    r_show   <= 1'b0;
                    // A hit always wins over a simultaneous frame tick.
                    if (iShipHit && r_lives != '0) begin
                        r_cnt    <= '0;
                        r_freeze <= 1'b1;
                        if (r_lives == ONE_LIFE) begin
                            r_state <= ST_GAME_OVER;
                            r_lives <= '0;
                            r_show  <= 1'b1;
`ifdef GO_BLINK_EN
                            r_blink_cnt <= '0;
`endif
                        end else begin
                            r_state <= ST_DYING;
                            r_lives <= r_lives - ONE_LIFE;
                        end
                    end
                end
                ST_DYING: begin
                    r_freeze <= 1'b1;
                    r_show   <= 1'b0;
                    if (iFrameTick) begin
                        if (r_cnt == RESP_LAST) begin
                            r_state   <= ST_PLAY;
                            r_cnt     <= '0;
                            r_freeze  <= 1'b0;
                            r_respawn <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_GAME_OVER: begin
                    r_freeze <= 1'b1;
                    if (w_start_edge && r_cnt == GO_HOLD) begin
                        r_state       <= ST_PLAY;
                        r_lives       <= LIVES0;
                        r_cnt         <= '0;
                        r_freeze      <= 1'b0;
                        r_show        <= 1'b0;
                        r_respawn     <= 1'b1;
                        r_reset_score <= 1'b1;
                    end else begin
                        if (iFrameTick && r_cnt != GO_HOLD)
                            r_cnt <= r_cnt + 1'b1;
`ifdef GO_BLINK_EN
                        if (iFrameTick) begin
                            if (r_blink_cnt == BLINK_LAST) begin
                                r_blink_cnt <= '0;
                                r_show      <= ~r_show;
                            end else begin
                                r_blink_cnt <= r_blink_cnt + 1'b1;
                            end
                        end
`else
                        r_show <= 1'b1;
`endif
                    end
                end
                default: begin
                    r_state  <= ST_ATTRACT;
                    r_freeze <= 1'b1;
                    r_show   <= 1'b0;
                end
            endcase
        end
    end

    assign oGameState  = r_state;
    assign oLives      = r_lives;
    assign oShowText   = r_show;
    assign oFreeze     = r_freeze;
    assign oRespawn    = r_respawn;
    assign oResetScore = r_reset_score;

endmodule
